// File: rtl/mode_input_conditioner.sv
// mode_input_conditioner
// Cleans up raw slide-switch / push-button inputs for the firmware input port.
// Each bit passes through its own synchronizer, a counter-based debouncer that
// only accepts a new level after it has been seen for DEBOUNCE_CYCLES
// consecutive sampled cycles, a registered edge detector, and a sticky event
// flag that firmware polls and clears. Bits are completely independent.
module mode_input_conditioner #(
    parameter int WIDTH           = 2,
    parameter int SYNC_STAGES     = 2,      // legal range 2..4
    parameter int DEBOUNCE_CYCLES = 500000  // minimum 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] event_sticky,
    input  logic [WIDTH-1:0] event_clear
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    // Value the counter holds on the edge a change is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_CHECKING = 1'b1
    } state_e;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync_bit;
        state_e                 state_q;
        logic [CNT_W-1:0]       cnt_q;
        logic                   level_q;
        logic                   rise_q;
        logic                   fall_q;
        logic                   sticky_q;
        logic                   sticky_d;

        // Shift the asynchronous input through the synchronizer chain.
        always_ff @(posedge clk) begin
            // NOTE: every sequential register uses <= so all flops sample the
            // pre-edge values, exactly like the hardware they describe.
            if (reset) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in[i]};
            end
        end

        assign sync_bit = sync_q[SYNC_STAGES-1];

        // Debounce FSM: accept a new level only after an unbroken run of
        // mismatching samples; any return to the current level restarts it.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= ST_STABLE;
                cnt_q   <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                unique case (state_q)
                    ST_STABLE: begin
                        if (sync_bit != level_q) begin
                            state_q <= ST_CHECKING;
                            cnt_q   <= cnt_q + CNT_W'(1);
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                    ST_CHECKING: begin
                        if (sync_bit == level_q) begin
                            // Bounce back before acceptance: no partial credit.
                            state_q <= ST_STABLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= ST_STABLE;
                            cnt_q   <= '0;
                            level_q <= sync_bit;
                            rise_q  <= sync_bit;
                            fall_q  <= ~sync_bit;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_STABLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end

        // Set beats clear, so an edge landing on a clear strobe is never lost.
        always_comb begin
            sticky_d = (sticky_q & ~event_clear[i]) | rise_q | fall_q;
        end

        // Hold the sticky event flag until firmware clears it.
        always_ff @(posedge clk) begin
            if (reset) begin
                sticky_q <= 1'b0;
            end else begin
                sticky_q <= sticky_d;
            end
        end

        assign level_out[i]    = level_q;
        assign rise_pulse[i]   = rise_q;
        assign fall_pulse[i]   = fall_q;
        assign event_sticky[i] = sticky_q;
    end

endmodule

// File: tb/tb_mode_input_conditioner.sv
// Testbench for mode_input_conditioner (WIDTH=2, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=8). The reference model treats the synchronizer as a plain
// S-cycle delay and accepts a new level once the last D delayed samples all
// differ from the current level.
module tb_mode_input_conditioner;

    localparam int W = 2;
    localparam int S = 2;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] raw_in;
    logic [W-1:0] event_clear;
    logic [W-1:0] level_out;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;
    logic [W-1:0] event_sticky;
    logic [4*W-1:0] dut_vec;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state
    logic [W-1:0] m_dl [S];
    bit           m_hist [W][$];
    logic [W-1:0] m_level;
    logic [W-1:0] m_rise;
    logic [W-1:0] m_fall;
    logic [W-1:0] m_sticky;

    mode_input_conditioner #(
        .WIDTH(W),
        .SYNC_STAGES(S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk),
        .reset(reset),
        .raw_in(raw_in),
        .level_out(level_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .event_sticky(event_sticky),
        .event_clear(event_clear)
    );

    always #5 clk = ~clk;

    assign dut_vec = {level_out, rise_pulse, fall_pulse, event_sticky};

    function automatic logic [4*W-1:0] mvec();
        return {m_level, m_rise, m_fall, m_sticky};
    endfunction

    task automatic model_clear();
        for (int k = 0; k < S; k++) m_dl[k] = '0;
        for (int i = 0; i < W; i++) m_hist[i].delete();
        m_level  = '0;
        m_rise   = '0;
        m_fall   = '0;
        m_sticky = '0;
    endtask

    // Advance the model by one rising edge using the inputs applied to it.
    task automatic model_edge();
        logic [W-1:0] seen;
        bit           all_diff;
        if (reset) begin
            model_clear();
        end else begin
            seen = m_dl[S-1];
            for (int k = S - 1; k > 0; k--) m_dl[k] = m_dl[k-1];
            m_dl[0] = raw_in;
            m_sticky = (m_sticky & ~event_clear) | m_rise | m_fall;
            for (int i = 0; i < W; i++) begin
                m_rise[i] = 1'b0;
                m_fall[i] = 1'b0;
                m_hist[i].push_back(seen[i]);
                if (m_hist[i].size() > D) void'(m_hist[i].pop_front());
                if (m_hist[i].size() == D) begin
                    all_diff = 1'b1;
                    foreach (m_hist[i][j]) if (m_hist[i][j] == m_level[i]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_level[i] = ~m_level[i];
                        m_rise[i]  = m_level[i];
                        m_fall[i]  = ~m_level[i];
                        m_hist[i].delete();
                    end
                end
            end
        end
    endtask

    // One clock: model and DUT update on the same edge, outputs sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic do_reset(input int n);
        reset       = 1'b1;
        raw_in      = '0;
        event_clear = '0;
        repeat (n) step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        raw_in      = '0;
        event_clear = '0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (dut_vec !== '0) begin
                errors++;
                $display("FAIL reset_during cyc=%0d got=%h exp=0", cyc, dut_vec);
            end
        end
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (dut_vec !== '0) begin
                errors++;
                $display("FAIL reset_after cyc=%0d got=%h exp=0", cyc, dut_vec);
            end
        end
    endtask

    task automatic test_clean_rise();
        do_reset(2);
        raw_in = 2'b01;
        for (int c = 1; c <= 11; c++) begin
            step();
            checks++;
            if (dut_vec !== mvec()) begin
                errors++;
                $display("FAIL clean_rise_model cyc=%0d got=%h exp=%h", cyc, dut_vec, mvec());
            end
            if (c == 9) begin
                checks++;
                if (level_out !== 2'b00 || rise_pulse !== 2'b00) begin
                    errors++;
                    $display("FAIL clean_rise_early level=%b rise=%b exp level=00 rise=00", level_out, rise_pulse);
                end
            end
            if (c == 10) begin
                checks++;
                if (level_out !== 2'b01 || rise_pulse !== 2'b01 || fall_pulse !== 2'b00 || event_sticky !== 2'b00) begin
                    errors++;
                    $display("FAIL clean_rise_edge10 level=%b rise=%b fall=%b sticky=%b exp 01/01/00/00",
                             level_out, rise_pulse, fall_pulse, event_sticky);
                end
            end
            if (c == 11) begin
                checks++;
                if (level_out !== 2'b01 || rise_pulse !== 2'b00 || event_sticky !== 2'b01) begin
                    errors++;
                    $display("FAIL clean_rise_edge11 level=%b rise=%b sticky=%b exp 01/00/01",
                             level_out, rise_pulse, event_sticky);
                end
            end
        end
    endtask

    task automatic test_glitch();
        bit pulse_seen = 1'b0;
        int rise_at    = -1;
        int fall_at    = -1;
        do_reset(2);
        for (int c = 1; c <= 25; c++) begin
            raw_in = (c <= 7) ? 2'b10 : 2'b00;
            step();
            if (rise_pulse[1] || fall_pulse[1]) pulse_seen = 1'b1;
            checks++;
            if (dut_vec !== mvec()) begin
                errors++;
                $display("FAIL glitch7_model cyc=%0d got=%h exp=%h", cyc, dut_vec, mvec());
            end
        end
        checks++;
        if (pulse_seen || level_out[1] !== 1'b0 || event_sticky[1] !== 1'b0) begin
            errors++;
            $display("FAIL glitch7_reject pulse_seen=%0d level1=%b sticky1=%b exp 0/0/0",
                     pulse_seen, level_out[1], event_sticky[1]);
        end
        // Nine-cycle pulse: must be accepted, then released.
        for (int c = 1; c <= 25; c++) begin
            raw_in = (c <= 9) ? 2'b10 : 2'b00;
            step();
            if (rise_pulse[1] && rise_at < 0) rise_at = c;
            if (fall_pulse[1] && fall_at < 0) fall_at = c;
            checks++;
            if (dut_vec !== mvec()) begin
                errors++;
                $display("FAIL glitch9_model cyc=%0d got=%h exp=%h", cyc, dut_vec, mvec());
            end
        end
        checks++;
        if (rise_at != 10 || fall_at != 19) begin
            errors++;
            $display("FAIL glitch9_accept rise_at=%0d fall_at=%0d exp 10/19", rise_at, fall_at);
        end
    endtask

    task automatic test_bounce();
        do_reset(2);
        raw_in = 2'b01;
        repeat (5) step();
        raw_in = 2'b00;
        step();
        raw_in = 2'b01;
        for (int c = 1; c <= 12; c++) begin
            step();
            checks++;
            if (dut_vec !== mvec()) begin
                errors++;
                $display("FAIL bounce_model cyc=%0d got=%h exp=%h", cyc, dut_vec, mvec());
            end
            if (c == 9 || c == 10) begin
                checks++;
                if (level_out[0] !== (c == 10) || rise_pulse[0] !== (c == 10)) begin
                    errors++;
                    $display("FAIL bounce_restart step=%0d level0=%b rise0=%b exp %0d/%0d",
                             c, level_out[0], rise_pulse[0], c == 10, c == 10);
                end
            end
        end
    endtask

    task automatic test_sticky_collision();
        do_reset(2);
        raw_in = 2'b01;
        repeat (10) step();
        checks++;
        if (rise_pulse !== 2'b01) begin
            errors++;
            $display("FAIL sticky_pulse rise=%b exp=01", rise_pulse);
        end
        event_clear = 2'b01;
        step();
        checks++;
        if (event_sticky[0] !== 1'b1) begin
            errors++;
            $display("FAIL sticky_set_wins sticky0=%b exp=1", event_sticky[0]);
        end
        step();
        checks++;
        if (event_sticky[0] !== 1'b0) begin
            errors++;
            $display("FAIL sticky_clear sticky0=%b exp=0", event_sticky[0]);
        end
        event_clear = 2'b00;
        step();
        checks++;
        if (dut_vec !== mvec() || event_sticky !== 2'b00) begin
            errors++;
            $display("FAIL sticky_stays_clear got=%h exp=%h", dut_vec, mvec());
        end
    endtask

    task automatic test_reset_mid();
        do_reset(2);
        raw_in = 2'b01;
        repeat (7) step();
        checks++;
        if (level_out !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_precount level=%b exp=00", level_out);
        end
        reset  = 1'b1;
        raw_in = 2'b11;
        step();
        checks++;
        if (dut_vec !== '0) begin
            errors++;
            $display("FAIL reset_mid_clear got=%h exp=0", dut_vec);
        end
        reset = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            step();
            checks++;
            if (dut_vec !== mvec()) begin
                errors++;
                $display("FAIL reset_mid_model cyc=%0d got=%h exp=%h", cyc, dut_vec, mvec());
            end
            if (c == 9) begin
                checks++;
                if (level_out !== 2'b00) begin
                    errors++;
                    $display("FAIL reset_mid_discard level=%b exp=00", level_out);
                end
            end
            if (c == 10) begin
                checks++;
                if (level_out !== 2'b11 || rise_pulse !== 2'b11) begin
                    errors++;
                    $display("FAIL reset_mid_both level=%b rise=%b exp 11/11", level_out, rise_pulse);
                end
            end
        end
    endtask

    task automatic test_random();
        int hold [W];
        do_reset(2);
        for (int i = 0; i < W; i++) hold[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < W; i++) begin
                if (hold[i] == 0) begin
                    raw_in[i] = 1'($urandom_range(0, 1));
                    hold[i]   = $urandom_range(1, 14);
                end
                hold[i]--;
            end
            event_clear = ($urandom_range(0, 5) == 0) ? W'($urandom_range(0, 3)) : '0;
            reset       = ($urandom_range(0, 399) == 0);
            step();
            checks++;
            if (dut_vec !== mvec()) begin
                errors++;
                $display("FAIL random_model cyc=%0d raw=%b got=%h exp=%h", cyc, raw_in, dut_vec, mvec());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        model_clear();
        reset       = 1'b1;
        raw_in      = '0;
        event_clear = '0;
        test_reset();
        test_clean_rise();
        test_glitch();
        test_bounce();
        test_sticky_collision();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
